// File: rtl/spe_clocked.sv
// Spiking processing element: buffers NoC packets in a small FIFO, accumulates
// signed partial sums into per-neuron membrane potentials, thresholds them and
// emits one spike-bitmap packet each time a timestep is closed.
module spe_clocked #(
   parameter int PE_ID       = 0,
   parameter int OUT_DEST    = 0,
   parameter int ADDR_W      = 4,
   parameter int OP_W        = 4,
   parameter int DATA_W      = 24,
   parameter int NUM_NEURONS = 8,
   parameter int POT_W       = 16,
   parameter int THRESHOLD   = 64,
   parameter int RESET_MODE  = 0,
   parameter int FIFO_DEPTH  = 4,
   localparam int PKT_W      = ADDR_W + OP_W + DATA_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PKT_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PKT_W-1:0] out_data,
   output logic             err_drop,
   output logic [7:0]       ts_count
);

   localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [OP_W-1:0] OP_PSUM   = OP_W'(1);
   localparam logic [OP_W-1:0] OP_END    = OP_W'(2);
   localparam logic [OP_W-1:0] OP_CLEAR  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_SPIKES = OP_W'(4);

   localparam logic signed [POT_W-1:0] THR     = POT_W'(THRESHOLD);
   localparam logic signed [POT_W-1:0] POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
   localparam logic signed [POT_W-1:0] POT_MIN = {1'b1, {(POT_W-1){1'b0}}};
   localparam logic [IDX_W:0]          NN_LIMIT = (IDX_W+1)'(NUM_NEURONS);
   localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0]        PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, EXEC, EMIT} state_t;

   state_t state;
   state_t state_next;

   // Input FIFO storage and bookkeeping
   logic [PKT_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   // Command register and decoded fields
   logic [PKT_W-1:0]         cmd;
   logic [ADDR_W-1:0]        cmd_dest;
   logic [OP_W-1:0]          cmd_op;
   logic [DATA_W-1:0]        cmd_data;
   logic [IDX_W-1:0]         cmd_idx;
   logic signed [POT_W-1:0]  cmd_psum;
   logic                     dest_ok;
   logic                     idx_ok;
   logic                     cmd_psum_ok;
   logic                     cmd_end;
   logic                     cmd_clear;
   logic                     cmd_bad;

   // Neuron state and accumulate path
   logic signed [POT_W-1:0]  pot [NUM_NEURONS];
   logic [NUM_NEURONS-1:0]   spike;
   logic signed [POT_W-1:0]  cur_pot;
   logic signed [POT_W:0]    wide_sum;
   logic signed [POT_W-1:0]  sat_sum;
   logic signed [POT_W-1:0]  new_pot;
   logic                     fire;
   logic [DATA_W-1:0]        emit_data;

   // in_ready depends only on the registered occupancy, so no combinational
   // path exists from in_valid back to in_ready.
   assign in_ready  = (count != CNT_FULL);
   assign push      = in_valid && in_ready;
   assign out_valid = (state == EMIT);

   assign cmd_dest    = cmd[PKT_W-1 -: ADDR_W];
   assign cmd_op      = cmd[DATA_W +: OP_W];
   assign cmd_data    = cmd[DATA_W-1:0];
   assign cmd_idx     = cmd_data[POT_W +: IDX_W];
   assign cmd_psum    = cmd_data[POT_W-1:0];
   assign dest_ok     = (cmd_dest == ADDR_W'(PE_ID));
   assign idx_ok      = ({1'b0, cmd_idx} < NN_LIMIT);
   assign cmd_psum_ok = dest_ok && (cmd_op == OP_PSUM) && idx_ok;
   assign cmd_end     = dest_ok && (cmd_op == OP_END);
   assign cmd_clear   = dest_ok && (cmd_op == OP_CLEAR);
   assign cmd_bad     = !(cmd_psum_ok || cmd_end || cmd_clear);

   // Data bits above the neuron index carry no meaning for any opcode.
   generate
      if (POT_W + IDX_W < DATA_W) begin : g_spare
         logic unused_data_bits;
         assign unused_data_bits = ^cmd_data[DATA_W-1:POT_W+IDX_W];
      end
   endgenerate

   // FIFO write port; storage needs no reset because occupancy gates reads
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= in_data;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Add the partial sum in one extra bit, then clamp to the signed potential range
   always_comb begin
      cur_pot  = idx_ok ? pot[cmd_idx] : '0;
      wide_sum = {cur_pot[POT_W-1], cur_pot} + {cmd_psum[POT_W-1], cmd_psum};
      sat_sum  = wide_sum[POT_W-1:0];
      if (wide_sum[POT_W] != wide_sum[POT_W-1]) begin
         sat_sum = wide_sum[POT_W] ? POT_MIN : POT_MAX;
      end
      fire    = (sat_sum >= THR);
      new_pot = sat_sum;
      if (fire) begin
         new_pot = (RESET_MODE != 0) ? '0 : sat_sum - THR;
      end
   end

   // Spike packet payload: source address on top, bitmap at the bottom
   always_comb begin
      emit_data = '0;
      emit_data[DATA_W-1 -: ADDR_W] = ADDR_W'(PE_ID);
      emit_data[NUM_NEURONS-1:0]    = spike;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic, FIFO pop and drop pulse
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      err_drop   = 1'b0;
      unique case (state)
         IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC: begin
            err_drop   = cmd_bad;
            state_next = cmd_end ? EMIT : IDLE;
         end
         EMIT: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Command capture, neuron updates, output latch and timestep counter
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd      <= '0;
         spike    <= '0;
         out_data <= '0;
         ts_count <= '0;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            pot[i] <= '0;
         end
      end else begin
         if (pop) begin
            cmd <= fifo_mem[rd_ptr];
         end
         if (state == EXEC) begin
            if (cmd_psum_ok) begin
               pot[cmd_idx] <= new_pot;
               if (fire) begin
                  spike[cmd_idx] <= 1'b1;
               end
            end
            if (cmd_clear) begin
               spike <= '0;
               for (int i = 0; i < NUM_NEURONS; i++) begin
                  pot[i] <= '0;
               end
            end
            if (cmd_end) begin
               out_data <= {ADDR_W'(OUT_DEST), OP_SPIKES, emit_data};
            end
         end
         if ((state == EMIT) && out_ready) begin
            spike    <= '0;
            ts_count <= ts_count + 8'd1;
         end
      end
   end

endmodule
